// File: rtl/rr_merge_pkg.sv
// Shared lane type and arbiter constants for the 2-to-1 round-robin merger.
package rr_merge_pkg;

  typedef logic lane_t;

  localparam lane_t LANE0    = 1'b0;
  localparam lane_t LANE1    = 1'b1;
  // Resetting last-grant to lane 1 makes lane 0 win the first tie.
  localparam lane_t LAST_RST = LANE1;

endpackage

// File: rtl/rr_merge_2x1_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; one instance buffers each merger lane.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  assign w_push   = push && (r_count != FULL_CNT);
  assign w_pop    = pop && (r_count != '0);
  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rr_merge_2x1.sv
// Round-robin 2-to-1 stream merger: per-lane FIFOs drained into a registered valid/ready output.
// Optional macro RR_MERGE_SRC_TAG_EN adds the out_src source-lane tag port.
module rr_merge_2x1
  import rr_merge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef RR_MERGE_SRC_TAG_EN
  ,
  output logic             out_src
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] w_head0, w_head1;
  logic [CW-1:0]    w_count0, w_count1;
  logic             w_full0, w_full1;
  logic             w_empty0, w_empty1;
  logic             w_free;
  logic             w_grant;
  lane_t            w_grant_lane;
  logic             w_pop0, w_pop1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  lane_t            r_last;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in0_valid),
    .push_data (in0_data),
    .pop       (w_pop0),
    .pop_data  (w_head0),
    .count     (w_count0),
    .full      (w_full0),
    .empty     (w_empty0)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in1_valid),
    .push_data (in1_data),
    .pop       (w_pop1),
    .pop_data  (w_head1),
    .count     (w_count1),
    .full      (w_full1),
    .empty     (w_empty1)
  );

  // Ready depends on occupancy only; a pop in the same cycle does not open a slot early.
  assign in0_ready = (w_count0 != CW'(DEPTH));
  assign in1_ready = (w_count1 != CW'(DEPTH));

  assign w_free = !r_out_valid || out_ready;

  always_comb begin
    w_grant      = 1'b0;
    w_grant_lane = LANE0;
    if (w_free) begin
      if (!w_empty0 && !w_empty1) begin
        w_grant      = 1'b1;
        w_grant_lane = ~r_last;
      end else if (!w_empty0) begin
        w_grant      = 1'b1;
        w_grant_lane = LANE0;
      end else if (!w_empty1) begin
        w_grant      = 1'b1;
        w_grant_lane = LANE1;
      end
    end
  end

  assign w_pop0 = w_grant && (w_grant_lane == LANE0);
  assign w_pop1 = w_grant && (w_grant_lane == LANE1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_last      <= LAST_RST;
    end else if (w_free) begin
      r_out_valid <= w_grant;
      if (w_grant) begin
        r_out_data <= (w_grant_lane == LANE1) ? w_head1 : w_head0;
        r_last     <= w_grant_lane;
      end
    end
  end

`ifdef RR_MERGE_SRC_TAG_EN
  lane_t r_out_src;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_src <= LANE0;
    end else if (w_free && w_grant) begin
      r_out_src <= w_grant_lane;
    end
  end

  assign out_src = r_out_src;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_rr_merge_2x1.sv
// Directed self-checking bench for rr_merge_2x1 (WIDTH=8, DEPTH=2); checks out_src when RR_MERGE_SRC_TAG_EN is defined.
module tb_rr_merge_2x1;

  logic       clk;
  logic       rst_n;
  logic       in0_valid, in0_ready;
  logic [7:0] in0_data;
  logic       in1_valid, in1_ready;
  logic [7:0] in1_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
`ifdef RR_MERGE_SRC_TAG_EN
  logic       out_src;
`endif

  int total = 0;
  int bad   = 0;

  rr_merge_2x1 #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef RR_MERGE_SRC_TAG_EN
    ,
    .out_src   (out_src)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] exp_data);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
  endtask

  initial begin
    rst_n = 1'b0; in0_valid = 1'b0; in0_data = 8'h00;
    in1_valid = 1'b0; in1_data = 8'h00; out_ready = 1'b0;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in0_ready", 32'(in0_ready), 32'd1);
    chk("rst_in1_ready", 32'(in1_ready), 32'd1);
    rst_n = 1'b1;

    // single lane: 0x11,0x22,0x33 on lane 0
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h11;
    tick();
    chk("single_lat_not_yet", 32'(out_valid), 32'd0);
    in0_data = 8'h22;
    tick();
    chk_beat("single_b0", 8'h11);
    in0_data = 8'h33;
    tick();
    chk_beat("single_b1", 8'h22);
    in0_valid = 1'b0;
    tick();
    chk_beat("single_b2", 8'h33);
    tick();
    chk("single_drain", 32'(out_valid), 32'd0);

    // reset mid-traffic discards output beat and buffered beat
    out_ready = 1'b0;
    in1_valid = 1'b1; in1_data = 8'h55;
    tick();
    in1_data = 8'h66;
    tick();
    chk_beat("midrst_pre", 8'h55);
    in1_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_in0_ready", 32'(in0_ready), 32'd1);
    chk("midrst_in1_ready", 32'(in1_ready), 32'd1);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("midrst_no_stale", 32'(out_valid), 32'd0);
    tick();
    chk("midrst_no_stale2", 32'(out_valid), 32'd0);

    // contention from reset: lane 0 wins the first tie, then alternate
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 8'hA0;
    in1_valid = 1'b1; in1_data = 8'hB0;
    tick();
    in0_data = 8'hA1; in1_data = 8'hB1;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk_beat("cont_b0", 8'hA0);
`ifdef RR_MERGE_SRC_TAG_EN
    chk("cont_src0", 32'(out_src), 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    chk_beat("cont_b1", 8'hB0);
`ifdef RR_MERGE_SRC_TAG_EN
    chk("cont_src1", 32'(out_src), 32'd1);
`endif
    tick();
    chk_beat("cont_b2", 8'hA1);
`ifdef RR_MERGE_SRC_TAG_EN
    chk("cont_src2", 32'(out_src), 32'd0);
`endif
    tick();
    chk_beat("cont_b3", 8'hB1);
`ifdef RR_MERGE_SRC_TAG_EN
    chk("cont_src3", 32'(out_src), 32'd1);
`endif
    tick();
    chk("cont_drain", 32'(out_valid), 32'd0);

    // backpressure: out_ready low for 5 edges while lane 1 pushes
    out_ready = 1'b0;
    in1_valid = 1'b1; in1_data = 8'hC0;
    tick();
    in1_data = 8'hC1;
    tick();
    chk_beat("bp_first", 8'hC0);
    chk("bp_ready_open", 32'(in1_ready), 32'd1);
    in1_data = 8'hC2;
    tick();
    chk("bp_ready_full", 32'(in1_ready), 32'd0);
    chk_beat("bp_hold0", 8'hC0);
    in1_data = 8'hC3;
    tick();
    chk("bp_ready_full2", 32'(in1_ready), 32'd0);
    chk_beat("bp_hold1", 8'hC0);
    tick();
    chk_beat("bp_hold2", 8'hC0);
    in1_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_beat("bp_rel0", 8'hC1);
    chk("bp_ready_back", 32'(in1_ready), 32'd1);
    tick();
    chk_beat("bp_rel1", 8'hC2);
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // full lane 0, rejected push, then push while popping
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 8'hD0;
    tick();
    in0_data = 8'hD1;
    tick();
    in0_data = 8'hD2;
    tick();
    chk("full_ready0", 32'(in0_ready), 32'd0);
    chk_beat("full_hold", 8'hD0);
    out_ready = 1'b1; in0_data = 8'hDE;
    tick();
    chk_beat("full_pop0", 8'hD1);
    chk("full_ready1", 32'(in0_ready), 32'd1);
    in0_data = 8'hD4;
    tick();
    chk_beat("full_pushpop", 8'hD2);
    chk("full_ready_pp", 32'(in0_ready), 32'd1);
    in0_data = 8'hD5;
    tick();
    chk_beat("full_b3", 8'hD4);
    in0_valid = 1'b0;
    tick();
    chk_beat("full_b4", 8'hD5);
    tick();
    chk("full_drain", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
